spi_master_multi: RTL

Parametrised SPI master, successor to the fixed 8-bit SPI_MASTER.
- Adds: configurable word width; all four CPOL/CPHA modes; programmable SCK divider; MSB/LSB-first; NUM_CS one-hot chip selects; explicit busy flag.
- Sits between a local controller and external or on-chip SPI slaves, e.g. SPI_SLAVE.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_clk_gen.sv | 49 ++++
 rtl/spi_master_multi.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the multi-mode SPI master.
//   spiState_t : transfer sequencer states (IDLE, SETUP, XFER, HOLD)
//   DEF_*      : default widths used by the top-level parameters
//   MODEn      : SPI mode encodings as {cpol, cpha}
//   csWidth()  : chip-select index width, never narrower than one bit
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spiState_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_NUM_CS = 4;
   localparam int DEF_DIV_W  = 8;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic int csWidth(input int numCs);
      return (numCs > 1) ? $clog2(numCs) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timing for the SPI master.
//   clk_c, reset_r : system clock, asynchronous active-high reset
//   restart        : pulse on transfer acceptance; clears both counters
//   run            : a transfer is in progress (divider counts)
//   edgeEn         : sequencer is in the data phase (SCK edges are counted)
//   div            : latched divider; half-period = div+1 cycles
//   tick           : last cycle of the current half-period
//   oddEdge        : the edge taken on this tick is edge 1, 3, 5, ...
//   lastEdge       : the edge taken on this tick is the final data-phase edge
module spi_clk_gen import spi_pkg::*; #(
   parameter int DIV_W = DEF_DIV_W,
   parameter int EDGES = 2 * DEF_DATA_W,
   localparam int EDGE_W = $clog2(EDGES) + 1
) (
   input  logic             clk_c,
   input  logic             reset_r,
   input  logic             restart,
   input  logic             run,
   input  logic             edgeEn,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             oddEdge,
   output logic             lastEdge
);

   logic [DIV_W-1:0]  divCnt;
   logic [EDGE_W-1:0] edgeCnt;   // data-phase edges already taken

   assign tick     = run && (divCnt == div);
   // edgeCnt counts completed edges, so the edge being taken now is edgeCnt+1
   assign oddEdge  = ~edgeCnt[0];
   assign lastEdge = edgeEn && tick && (edgeCnt == EDGE_W'(EDGES - 1));

   always_ff @(posedge clk_c or posedge reset_r) begin
      if (reset_r) begin
         divCnt  <= '0;
         edgeCnt <= '0;
      end else if (restart) begin
         divCnt  <= '0;
         edgeCnt <= '0;
      end else if (run) begin
         divCnt <= tick ? '0 : divCnt + 1'b1;
         // saturate at the terminal count rather than wrapping
         if (edgeEn && tick && (edgeCnt != EDGE_W'(EDGES)))
            edgeCnt <= edgeCnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: DATA_W-bit words, all four CPOL/CPHA modes,
// programmable SCK divider, MSB/LSB-first, NUM_CS active-low chip selects.
//   clk_c, reset_r       : system clock, asynchronous active-high reset
//   start_i              : request; accepted when idle and csSel_i < NUM_CS
//   cpol_i/cpha_i        : SPI mode, latched at acceptance
//   lsbFirst_i           : bit order, latched at acceptance
//   clkDiv_i             : SCK half-period = clkDiv_i+1 clk_c cycles
//   csSel_i              : slave index
//   inputData_i          : word to send
//   miso_i / mosi_o      : serial data in / out
//   sck_o                : SPI clock (idles at cpol)
//   cs_n_o               : one-hot-low chip selects
//   busy_o               : transfer in progress
//   transferCompleted_o  : single-cycle completion pulse
//   fullDataFromSlave_o  : last received word, held until next completion
//   state_o              : sequencer state, for observation
//
// Handshake: a request is taken on any clock edge where start_i=1, busy_o=0
// and csSel_i is in range; busy_o is high from the following cycle until the
// cycle carrying transferCompleted_o, where it is already low so a new
// request can be taken on the very next edge.
module spi_master_multi import spi_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_CS = DEF_NUM_CS,
   parameter int DIV_W  = DEF_DIV_W,
   localparam int CSW   = csWidth(NUM_CS)
) (
   input  logic              clk_c,
   input  logic              reset_r,
   input  logic              start_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic              lsbFirst_i,
   input  logic [DIV_W-1:0]  clkDiv_i,
   input  logic [CSW-1:0]    csSel_i,
   input  logic [DATA_W-1:0] inputData_i,
   input  logic              miso_i,
   output logic              mosi_o,
   output logic              sck_o,
   output logic [NUM_CS-1:0] cs_n_o,
   output logic              busy_o,
   output logic              transferCompleted_o,
   output logic [DATA_W-1:0] fullDataFromSlave_o,
   output spiState_t         state_o
);

   spiState_t         state;
   logic              cpolQ, cphaQ, lsbQ;
   logic [DIV_W-1:0]  divQ;
   logic [DATA_W-1:0] txShift;
   logic [DATA_W-1:0] rxShift;

   logic tick, oddEdge, lastEdge;
   logic accept, csInRange, sampleEdge, driveEdge;

   assign state_o   = state;
   assign csInRange = int'(csSel_i) < NUM_CS;
   assign accept    = (state == IDLE) && start_i && csInRange;

   // Leading-edge sampling for CPHA=0 modes, trailing-edge for CPHA=1.
   always_comb begin
      sampleEdge = oddEdge;
      case ({cpolQ, cphaQ})
         MODE0, MODE2: sampleEdge = oddEdge;
         MODE1, MODE3: sampleEdge = ~oddEdge;
         default:      sampleEdge = oddEdge;
      endcase
   end

   // The final edge never launches a new bit (it is a sample edge for CPHA=1
   // and the closing edge for CPHA=0).
   assign driveEdge = ~sampleEdge && ~lastEdge;

   spi_clk_gen #(
      .DIV_W (DIV_W),
      .EDGES (2 * DATA_W)
   ) clkGen (
      .clk_c    (clk_c),
      .reset_r  (reset_r),
      .restart  (accept),
      .run      (busy_o),
      .edgeEn   (state == XFER),
      .div      (divQ),
      .tick     (tick),
      .oddEdge  (oddEdge),
      .lastEdge (lastEdge)
   );

   always_ff @(posedge clk_c or posedge reset_r) begin
      if (reset_r) begin
         state               <= IDLE;
         cpolQ               <= 1'b0;
         cphaQ               <= 1'b0;
         lsbQ                <= 1'b0;
         divQ                <= '0;
         txShift             <= '0;
         rxShift             <= '0;
         mosi_o              <= 1'b0;
         sck_o               <= 1'b0;
         cs_n_o              <= '1;
         busy_o              <= 1'b0;
         transferCompleted_o <= 1'b0;
         fullDataFromSlave_o <= '0;
      end else begin
         transferCompleted_o <= 1'b0;
         case (state)
            IDLE: begin
               sck_o <= cpol_i;
               if (accept) begin
                  state   <= SETUP;
                  busy_o  <= 1'b1;
                  cs_n_o  <= ~(NUM_CS'(1) << csSel_i);
                  cpolQ   <= cpol_i;
                  cphaQ   <= cpha_i;
                  lsbQ    <= lsbFirst_i;
                  divQ    <= clkDiv_i;
                  rxShift <= '0;
                  txShift <= inputData_i;
                  // CPHA=0 slaves sample on the first edge, so the first bit
                  // must already be on the wire when CS falls.
                  if (!cpha_i) begin
                     mosi_o  <= lsbFirst_i ? inputData_i[0] : inputData_i[DATA_W-1];
                     txShift <= lsbFirst_i ? (inputData_i >> 1) : (inputData_i << 1);
                  end
               end
            end
            SETUP: begin
               if (tick) state <= XFER;
            end
            XFER: begin
               if (tick) begin
                  sck_o <= ~sck_o;
                  if (sampleEdge)
                     rxShift <= lsbQ ? {miso_i, rxShift[DATA_W-1:1]}
                                     : {rxShift[DATA_W-2:0], miso_i};
                  if (driveEdge) begin
                     mosi_o  <= lsbQ ? txShift[0] : txShift[DATA_W-1];
                     txShift <= lsbQ ? (txShift >> 1) : (txShift << 1);
                  end
                  if (lastEdge) state <= HOLD;
               end
            end
            HOLD: begin
               if (tick) begin
                  state               <= IDLE;
                  busy_o              <= 1'b0;
                  cs_n_o              <= '1;
                  transferCompleted_o <= 1'b1;
                  fullDataFromSlave_o <= rxShift;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
